// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in, serial-out shift register. Sends each word MSB-first
//             with a valid/ready load handshake and per-bit backpressure.
//             Define PISO_PARITY_EN to append an even-parity bit to each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic w_in_shift;
    logic w_at_last;
    logic w_beat;
    logic w_load_hs;
    logic w_data_bit;

    assign w_in_shift = (state_q == SHIFT);
    assign w_at_last  = w_in_shift && (cnt_q == LAST_CNT);
    assign w_beat     = w_in_shift && serial_ready;

    // The load window reopens on the final beat so back-to-back frames have no gap.
    assign load_ready = !reset && (!w_in_shift || (w_at_last && serial_ready));
    assign w_load_hs  = load_valid && load_ready;

`ifdef PISO_PARITY_EN
    // Once all data bits have shifted out, the trailing slot carries the parity.
    assign w_data_bit = (cnt_q == CW'(WIDTH)) ? parity_q : shreg_q[WIDTH-1];
`else
    assign w_data_bit = shreg_q[WIDTH-1];
`endif

    assign serial_out   = w_in_shift & w_data_bit;
    assign serial_valid = w_in_shift;
    assign busy         = w_in_shift;
    assign last_bit     = w_at_last;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_load_hs) begin
                    state_d  = SHIFT;
                    shreg_d  = parallel_in;
                    cnt_d    = '0;
`ifdef PISO_PARITY_EN
                    parity_d = ^parallel_in;
`endif
                end
            end
            SHIFT: begin
                if (w_beat) begin
                    if (w_at_last) begin
                        if (w_load_hs) begin
                            shreg_d  = parallel_in;
                            cnt_d    = '0;
`ifdef PISO_PARITY_EN
                            parity_d = ^parallel_in;
`endif
                        end else begin
                            state_d = IDLE;
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                            cnt_d   = '0;
                        end
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Purpose  : Scoreboard bench for piso_serializer: directed and random traffic
//             checked against a frame-level queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] parallel_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         serial_ready = 1'b0;
    logic         last_bit;
    logic         busy;

    piso_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .last_bit     (last_bit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    bit armed  = 1'b0;
    int remaining = 0;           // bits of the frame in flight still to be sent
    logic [1:0] sb[$];           // {last flag, bit}

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--)
            sb.push_back({(FL == W) && (i == 0), w[i]});
`ifdef PISO_PARITY_EN
        sb.push_back({1'b1, ^w});
`endif
    endtask

    // One clock cycle: check state from the previous edge, drive new inputs,
    // then advance the model for the edge that closes this cycle.
    task automatic cycle(input logic rst, input logic lv, input logic [W-1:0] pin,
                         input logic sr);
        logic exp_ready;
        @(posedge clk);
        #2;
        if (armed) begin
            chk("serial_valid", serial_valid, remaining > 0);
            chk("busy", busy, remaining > 0);
            chk("last_bit", last_bit, remaining == 1);
            if (remaining == 0) chk("serial_out_idle", serial_out, 1'b0);
        end
        reset        = rst;
        load_valid   = lv;
        parallel_in  = pin;
        serial_ready = sr;
        #1;
        exp_ready = !rst && (remaining == 0 || (remaining == 1 && sr));
        chk("load_ready", load_ready, exp_ready);
        if (rst) begin
            remaining = 0;
            sb.delete();
            armed = 1'b1;
        end else begin
            if (remaining > 0 && sr) remaining--;
            if (lv && exp_ready) begin
                remaining = FL;
                push_frame(pin);
            end
        end
    endtask

    // Monitor: every beat pops the next expected bit.
    always @(negedge clk) begin
        if (armed && !reset && serial_valid === 1'b1 && serial_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
                logic [1:0] e;
                e = sb.pop_front();
                chk("serial_out", serial_out, e[0]);
                chk("last_flag", last_bit, e[1]);
            end
        end
    end

    initial begin
        int drained;
        // Reset held with load_valid asserted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h5A, 1'b1);
        // Single frame 0xA5 at full rate.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        // Back-to-back 0xA5, 0x3C with load_valid held.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < FL - 1; i++) cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, 1'b0, 8'hFF, 1'b1);
        // 0xC3 with a 3-cycle stall on the second bit.
        cycle(1'b0, 1'b1, 8'hC3, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        // 0xFF aborted by reset on its fourth bit, then 0x01.
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        // Parity-sensitive word 0x07.
        cycle(1'b0, 1'b1, 8'h07, 1'b1);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        // Random traffic with backpressure and occasional resets.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                  W'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < FL + 2; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        drained = sb.size();
        total++;
        if (drained != 0)
            $display("FAIL scoreboard_drain: %0d bits left, expected 0", drained);
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
